// File: rtl/basic_and_pkg.sv
// Shared constants and helpers for the basic_and bitwise-AND block.
package basic_and_pkg;

    localparam int MAX_WIDTH = 64;

    // True when every bit of the (zero-extended) operand is 0.
    function automatic logic all_zero(input logic [MAX_WIDTH-1:0] v);
        return ~|v;
    endfunction

endpackage

// File: rtl/basic_and_reg.sv
// Valid-qualified capture register for the AND result, with a zero flag.
module basic_and_reg
    import basic_and_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             q_zero
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_d;
    logic             valid_q;
    logic             zero_d;
    logic             zero_q;

    // Next-state: reset beats a coincident sample; idle cycles hold data/flag.
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        zero_d  = zero_q;
        if (reset) begin
            data_d  = '0;
            valid_d = 1'b0;
            zero_d  = 1'b0;
        end else if (d_valid) begin
            data_d  = d;
            valid_d = 1'b1;
            zero_d  = all_zero(MAX_WIDTH'(d));
        end else begin
            data_d  = data_q;
            valid_d = 1'b0;
            zero_d  = zero_q;
        end
    end

    // State registers; reset is folded into the next-state logic above.
    always_ff @(posedge clk) begin
        data_q  <= data_d;
        valid_q <= valid_d;
        zero_q  <= zero_d;
    end

    assign q       = data_q;
    assign q_valid = valid_q;
    assign q_zero  = zero_q;

endmodule

// File: rtl/basic_and.sv
// Bitwise AND of two operands: combinational result plus registered copy.
module basic_and
    import basic_and_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid,
    output logic             out_zero
);

    // Zero-latency path: independent of clk and reset.
    assign out = a & b;

    basic_and_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk     (clk),
        .reset   (reset),
        .d       (out),
        .d_valid (in_valid),
        .q       (out_q),
        .q_valid (out_valid),
        .q_zero  (out_zero)
    );

endmodule

// File: tb/tb_basic_and.sv
// Scoreboard bench for basic_and (WIDTH=4) driven by hand-computed vectors.
module tb_basic_and;

    localparam int W = 4;
    localparam int NV = 11;

    logic         clk;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_valid;
    logic [W-1:0] out;
    logic [W-1:0] out_q;
    logic         out_valid;
    logic         out_zero;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         v;
        logic         r;
        logic [W-1:0] exp_out;
        logic [W-1:0] exp_q;
        logic         exp_zero;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic         zero;
    } exp_t;

    vec_t vecs[NV];
    exp_t sb[$];

    basic_and #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests_run = tests_run + 1;
                tests_failed = tests_failed + 1;
                $display("FAIL unexpected_valid: got out_valid=1 out_q=%b expected no result", out_q);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_out_q", out_q, e.q);
                check("sb_out_zero", {3'b000, out_zero}, {3'b000, e.zero});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish within 100000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        //           a        b        v     r     out      held q   held zero
        vecs[0]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1};
        vecs[1]  = '{4'b1111, 4'b0101, 1'b1, 1'b0, 4'b0101, 4'b0101, 1'b0};
        vecs[2]  = '{4'b1100, 4'b1111, 1'b1, 1'b0, 4'b1100, 4'b1100, 1'b0};
        vecs[3]  = '{4'b1100, 4'b0011, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1};
        vecs[4]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1};
        vecs[5]  = '{4'b1100, 4'b1010, 1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0};
        vecs[6]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0};
        vecs[7]  = '{4'b0110, 4'b0111, 1'b1, 1'b0, 4'b0110, 4'b0110, 1'b0};
        vecs[8]  = '{4'b1011, 4'b1001, 1'b0, 1'b0, 4'b1001, 4'b0110, 1'b0};
        vecs[9]  = '{4'b0011, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0};
        vecs[10] = '{4'b1001, 4'b0110, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1};

        reset    = 1'b1;
        a        = 4'b1010;
        b        = 4'b0110;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", out, 4'b0010);
        check("reset_out_q", out_q, 4'b0000);
        check("reset_out_valid", {3'b000, out_valid}, 4'b0000);
        check("reset_out_zero", {3'b000, out_zero}, 4'b0000);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset    = vecs[i].r;
            a        = vecs[i].a;
            b        = vecs[i].b;
            in_valid = vecs[i].v;
            if (vecs[i].v && !vecs[i].r)
                sb.push_back('{vecs[i].exp_q, vecs[i].exp_zero});
            #1;
            check($sformatf("comb_out[%0d]", i), out, vecs[i].exp_out);
            if (!vecs[i].v || vecs[i].r) begin
                @(posedge clk);
                #1;
                check($sformatf("idle_valid[%0d]", i), {3'b000, out_valid}, 4'b0000);
                check($sformatf("idle_q[%0d]", i), out_q, vecs[i].exp_q);
                check($sformatf("idle_zero[%0d]", i), {3'b000, out_zero}, {3'b000, vecs[i].exp_zero});
            end
        end

        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size() == 0 ? 4'b0000 : 4'b0001, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
